urxd_bl_commit: RTL and testbench
=================================

Name: urxd_bl_commit

Overview:
- Sequencer placed behind the UART block receiver. Each byte of a data block arrives on the receiver's per-byte write strobe and is held in an internal staging buffer.
- When the block-received-with-good-CRC pulse arrives, the block is copied into the shared target memory through a request/grant write port.
- A bad-CRC, truncated or overflowing block is discarded and never reaches memory, so a corrupted frame cannot partially overwrite the target.

Parameters:
- DEPTH, 256, staging buffer size in bytes; power of two, AW = log2(DEPTH).
- TOUT, 50000, idle clk cycles after the last data byte before a block with no ok pulse is declared failed.
- CW, 17, timeout counter width; must hold TOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_dat  in  8  received data byte from block receiver
- adr  in  16  receiver's current write address (valid with ce_wr_dat)
- ce_wr_dat  in  1  one-cycle strobe: rx_dat/adr hold a data byte
- ok_rx_bl  in  1  one-cycle pulse: block finished, CRC good
- mem_req  out  1  controller requests the target memory write port
- mem_gnt  in  1  arbiter grant; may be asserted or withdrawn any cycle
- mem_we  out  1  write strobe = mem_req & mem_gnt (combinational)
- mem_adr  out  16  target write address
- mem_dat  out  8  target write data
- busy  out  1  high in FILL or COMMIT
- bl_ok  out  1  one-cycle pulse: block committed (or empty block acknowledged)
- bl_len  out  AW+1  byte count of the last committed block; held until the next bl_ok
- err_cnt  out  8  dropped-block counter, saturates at 255

Behaviour:
- Reset values: state IDLE; mem_req=0, mem_we=0, mem_adr=0, mem_dat=0, busy=0, bl_ok=0, bl_len=0, err_cnt=0. Internal n, idx, timer and ovf all 0. Buffer contents are not reset.
- Staging buffer: DEPTH x 8 array with asynchronous read (distributed RAM) and synchronous write.
- IDLE:
  - ce_wr_dat: buf[0]<=rx_dat, base<=adr, n<=1, timer<=0, go to FILL.
  - ok_rx_bl with no data (non-write command, or zero length): bl_ok pulses the next cycle, bl_len<=0, stay in IDLE.
- FILL:
  - ce_wr_dat with n<DEPTH: buf[n]<=rx_dat, n<=n+1, timer<=0.
  - ce_wr_dat with n==DEPTH: byte is dropped, ovf<=1, timer<=0.
  - Otherwise timer increments each cycle.
  - ok_rx_bl with ovf=0: idx<=0, go to COMMIT.
  - ok_rx_bl with ovf=1: err_cnt+1, go to IDLE.
  - timer==TOUT-1 with no ok_rx_bl: err_cnt+1, go to IDLE.
  - ok_rx_bl and ce_wr_dat in the same cycle: the byte is stored first, then the ok is applied, so the byte counts in n.
- COMMIT:
  - mem_req=1, mem_adr=base+idx (16-bit wrap, 0xFFFF+1 -> 0x0000), mem_dat=buf[idx].
  - On each cycle with mem_gnt=1: one write, idx<=idx+1.
  - When mem_gnt=0: outputs hold, idx holds, no write.
  - Write of idx==n-1 granted: next cycle bl_ok=1 for 1 cycle, bl_len<=n, mem_req<=0, go to IDLE.
  - Latency from ok_rx_bl to first mem_we: 1 cycle (given grant). Full block takes n granted cycles.
  - ce_wr_dat or ok_rx_bl during COMMIT: ignored; err_cnt+1 once per COMMIT (lost flag). The committing block is unaffected.
- busy=1 in FILL and COMMIT.
- err_cnt saturates at 255; the two increment sources never coincide.
- rst in any state: immediate return to IDLE. An in-flight commit is aborted, with no further mem_we, and err_cnt is cleared.

Test Plan:
- Good block: IDLE, 4 strobes adr 0x0100..0x0103 data A1,B2,C3,D4, then ok_rx_bl, mem_gnt=1 -> mem_we 4 consecutive cycles starting 1 cycle after ok, addr 0x0100..0x0103 with A1..D4; then bl_ok pulse, bl_len=4, busy=0.
- Bad CRC: 3 bytes, no ok, TOUT=16 -> mem_we never asserted; err_cnt 0->1 16 cycles after the last strobe; state IDLE.
- Grant stalls: 3-byte block, mem_gnt toggling 1,0,0,1,1 -> exactly 3 writes, on the granted cycles only, in address order; bl_ok after the third.
- Overflow: DEPTH=8, 10 strobes then ok_rx_bl -> no mem_we, err_cnt+1. Then a following 2-byte good block commits normally.
- Address wrap and edges: base 0xFFFE, 3 bytes -> addresses 0xFFFE, 0xFFFF, 0x0000. A strobe during COMMIT -> err_cnt+1 and committed data unchanged. rst asserted mid-COMMIT -> mem_req=0 next cycle, err_cnt=0.

Source files
------------

// File: rtl/urxd_bl_commit.sv
// Stages one UART data block and copies it into target memory only after a good-CRC pulse.
// Bad, truncated or overflowing blocks are dropped and counted in err_cnt.
module urxd_bl_commit #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned TOUT  = 50000,
    parameter int unsigned CW    = 17,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_dat,
    input  logic [15:0]   adr,
    input  logic          ce_wr_dat,
    input  logic          ok_rx_bl,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic          mem_we,
    output logic [15:0]   mem_adr,
    output logic [7:0]    mem_dat,
    output logic          busy,
    output logic          bl_ok,
    output logic [AW:0]   bl_len,
    output logic [7:0]    err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT} state_e;

    state_e          state_q, state_d;
    logic [AW:0]     n_q, n_d;
    logic [AW:0]     idx_q, idx_d;
    logic [AW:0]     idx_nx;
    logic [CW-1:0]   timer_q, timer_d;
    logic            ovf_q, ovf_d;
    logic            ovf_now;
    logic            lost_q, lost_d;
    logic [15:0]     base_q, base_d;
    logic            mem_req_q, mem_req_d;
    logic [15:0]     mem_adr_q, mem_adr_d;
    logic [7:0]      mem_dat_q, mem_dat_d;
    logic            busy_q;
    logic            bl_ok_q, bl_ok_d;
    logic [AW:0]     bl_len_q, bl_len_d;
    logic [7:0]      err_q, err_d;
    logic            err_inc;
    logic            stg_we;
    logic [AW-1:0]   stg_wa;
    logic [7:0]      stage_q [DEPTH];

    // Next-state, staging-write and memory-port decode
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        ovf_d     = ovf_q;
        ovf_now   = 1'b0;
        lost_d    = lost_q;
        base_d    = base_q;
        mem_req_d = mem_req_q;
        mem_adr_d = mem_adr_q;
        mem_dat_d = mem_dat_q;
        bl_ok_d   = 1'b0;
        bl_len_d  = bl_len_q;
        err_inc   = 1'b0;
        stg_we    = 1'b0;
        stg_wa    = n_q[AW-1:0];
        idx_nx    = idx_q + (AW+1)'(1);

        case (state_q)
            S_IDLE: begin
                if (ce_wr_dat) begin
                    stg_we  = 1'b1;
                    stg_wa  = '0;
                    base_d  = adr;
                    n_d     = (AW+1)'(1);
                    timer_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_FILL;
                end else if (ok_rx_bl) begin
                    bl_ok_d  = 1'b1;
                    bl_len_d = '0;
                end
            end

            S_FILL: begin
                ovf_now = ovf_q;
                if (ce_wr_dat) begin
                    timer_d = '0;
                    if (n_q == (AW+1)'(DEPTH)) begin
                        ovf_d   = 1'b1;
                        ovf_now = 1'b1;
                    end else begin
                        stg_we = 1'b1;
                        n_d    = n_q + (AW+1)'(1);
                    end
                end else begin
                    timer_d = timer_q + CW'(1);
                end
                // A byte arriving with the ok pulse is part of the block
                if (ok_rx_bl) begin
                    if (ovf_now) begin
                        err_inc = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d     = '0;
                        lost_d    = 1'b0;
                        mem_req_d = 1'b1;
                        mem_adr_d = base_q;
                        mem_dat_d = stage_q[0];
                        state_d   = S_COMMIT;
                    end
                end else if (!ce_wr_dat && timer_q == CW'(TOUT - 1)) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_COMMIT: begin
                if ((ce_wr_dat || ok_rx_bl) && !lost_q) begin
                    lost_d  = 1'b1;
                    err_inc = 1'b1;
                end
                if (mem_gnt) begin
                    if (idx_q == n_q - (AW+1)'(1)) begin
                        bl_ok_d   = 1'b1;
                        bl_len_d  = n_q;
                        mem_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        idx_d     = idx_nx;
                        mem_adr_d = base_q + 16'(idx_nx);
                        mem_dat_d = stage_q[idx_nx[AW-1:0]];
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            ovf_q     <= 1'b0;
            lost_q    <= 1'b0;
            base_q    <= '0;
            mem_req_q <= 1'b0;
            mem_adr_q <= '0;
            mem_dat_q <= '0;
            busy_q    <= 1'b0;
            bl_ok_q   <= 1'b0;
            bl_len_q  <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            ovf_q     <= ovf_d;
            lost_q    <= lost_d;
            base_q    <= base_d;
            mem_req_q <= mem_req_d;
            mem_adr_q <= mem_adr_d;
            mem_dat_q <= mem_dat_d;
            busy_q    <= (state_d != S_IDLE);
            bl_ok_q   <= bl_ok_d;
            bl_len_q  <= bl_len_d;
            err_q     <= err_d;
        end
    end

    // Staging buffer: synchronous write, asynchronous read, contents not reset
    always_ff @(posedge clk) begin
        if (stg_we && !rst) begin
            stage_q[stg_wa] <= rx_dat;
        end
    end

    assign mem_req = mem_req_q;
    assign mem_we  = mem_req_q & mem_gnt;
    assign mem_adr = mem_adr_q;
    assign mem_dat = mem_dat_q;
    assign busy    = busy_q;
    assign bl_ok   = bl_ok_q;
    assign bl_len  = bl_len_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_urxd_bl_commit.sv
// Directed bench for urxd_bl_commit with a small buffer (8 bytes) and short timeout (16 cycles).
module tb_urxd_bl_commit;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TOUT  = 16;
    localparam int unsigned CW    = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_dat;
    logic [15:0] adr;
    logic        ce_wr_dat;
    logic        ok_rx_bl;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [7:0]  mem_dat;
    logic        busy;
    logic        bl_ok;
    logic [3:0]  bl_len;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    urxd_bl_commit #(.DEPTH(DEPTH), .TOUT(TOUT), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_dat    (rx_dat),
        .adr       (adr),
        .ce_wr_dat (ce_wr_dat),
        .ok_rx_bl  (ok_rx_bl),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_dat   (mem_dat),
        .busy      (busy),
        .bl_ok     (bl_ok),
        .bl_len    (bl_len),
        .err_cnt   (err_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0;
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          wc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory write log, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_adr);
            wd_q.push_back(mem_dat);
            wc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] d);
        ce_wr_dat = 1'b1;
        adr       = a;
        rx_dat    = d;
        tick();
        ce_wr_dat = 1'b0;
    endtask

    task automatic clr_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [15:0] a, input logic [7:0] d);
        chk({tag, "_adr"}, 32'(wa_q[i]), 32'(a));
        chk({tag, "_dat"}, 32'(wd_q[i]), 32'(d));
    endtask

    initial begin
        rst = 1'b1; rx_dat = '0; adr = '0; ce_wr_dat = 1'b0; ok_rx_bl = 1'b0; mem_gnt = 1'b0;
        repeat (2) tick();
        chk("rst_req",  32'(mem_req), 0);
        chk("rst_we",   32'(mem_we), 0);
        chk("rst_adr",  32'(mem_adr), 0);
        chk("rst_dat",  32'(mem_dat), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_blok", 32'(bl_ok), 0);
        chk("rst_len",  32'(bl_len), 0);
        chk("rst_err",  32'(err_cnt), 0);
        rst = 1'b0;
        tick();

        // Good 4-byte block, continuous grant
        clr_log();
        mem_gnt = 1'b1;
        send(16'h0100, 8'hA1); send(16'h0101, 8'hB2); send(16'h0102, 8'hC3); send(16'h0103, 8'hD4);
        chk("t1_fill_busy", 32'(busy), 1);
        chk("t1_fill_req",  32'(mem_req), 0);
        c0 = cyc;
        ok_rx_bl = 1'b1; tick(); ok_rx_bl = 1'b0;
        chk("t1_req",  32'(mem_req), 1);
        chk("t1_adr0", 32'(mem_adr), 32'h0100);
        repeat (4) tick();
        chk("t1_blok", 32'(bl_ok), 1);
        chk("t1_len",  32'(bl_len), 4);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_req_off", 32'(mem_req), 0);
        chk("t1_nwr",  32'(wa_q.size()), 4);
        chk_wr("t1_w0", 0, 16'h0100, 8'hA1);
        chk_wr("t1_w1", 1, 16'h0101, 8'hB2);
        chk_wr("t1_w2", 2, 16'h0102, 8'hC3);
        chk_wr("t1_w3", 3, 16'h0103, 8'hD4);
        chk("t1_lat",  32'(wc_q[0]), 32'(c0 + 1));
        chk("t1_last", 32'(wc_q[3]), 32'(c0 + 4));
        tick();
        chk("t1_blok_pulse", 32'(bl_ok), 0);
        chk("t1_len_hold",   32'(bl_len), 4);

        // Bad CRC: no ok pulse, timeout drops the block
        clr_log();
        send(16'h0200, 8'h01); send(16'h0201, 8'h02); send(16'h0202, 8'h03);
        repeat (15) tick();
        chk("t2_err_early", 32'(err_cnt), 0);
        chk("t2_busy_early", 32'(busy), 1);
        tick();
        chk("t2_err",  32'(err_cnt), 1);
        chk("t2_busy", 32'(busy), 0);
        chk("t2_nwr",  32'(wa_q.size()), 0);

        // Grant stalls: 1,0,0,1,1
        clr_log();
        send(16'h0300, 8'h31); send(16'h0301, 8'h32); send(16'h0302, 8'h33);
        c0 = cyc;
        ok_rx_bl = 1'b1; tick(); ok_rx_bl = 1'b0;
        tick(); mem_gnt = 1'b0;
        chk("t3_stall_req", 32'(mem_req), 1);
        chk("t3_stall_adr", 32'(mem_adr), 32'h0301);
        chk("t3_stall_dat", 32'(mem_dat), 32'h32);
        tick();
        tick(); mem_gnt = 1'b1;
        tick();
        tick();
        chk("t3_blok", 32'(bl_ok), 1);
        chk("t3_len",  32'(bl_len), 3);
        chk("t3_nwr",  32'(wa_q.size()), 3);
        chk_wr("t3_w0", 0, 16'h0300, 8'h31);
        chk_wr("t3_w1", 1, 16'h0301, 8'h32);
        chk_wr("t3_w2", 2, 16'h0302, 8'h33);
        chk("t3_c0", 32'(wc_q[0]), 32'(c0 + 1));
        chk("t3_c1", 32'(wc_q[1]), 32'(c0 + 4));
        chk("t3_c2", 32'(wc_q[2]), 32'(c0 + 5));

        // Overflow: 10 bytes into an 8-byte buffer, then a normal 2-byte block
        clr_log();
        for (int i = 0; i < 10; i++) send(16'h0400 + 16'(i), 8'h40 + 8'(i));
        ok_rx_bl = 1'b1; tick(); ok_rx_bl = 1'b0;
        chk("t4_err",  32'(err_cnt), 2);
        chk("t4_busy", 32'(busy), 0);
        tick();
        chk("t4_nwr",  32'(wa_q.size()), 0);
        send(16'h0420, 8'h5A); send(16'h0421, 8'hA5);
        ok_rx_bl = 1'b1; tick(); ok_rx_bl = 1'b0;
        repeat (2) tick();
        chk("t4_blok", 32'(bl_ok), 1);
        chk("t4_len",  32'(bl_len), 2);
        chk("t4_nwr2", 32'(wa_q.size()), 2);
        chk_wr("t4_w0", 0, 16'h0420, 8'h5A);
        chk_wr("t4_w1", 1, 16'h0421, 8'hA5);

        // Address wrap; last byte arrives together with the ok pulse
        clr_log();
        send(16'hFFFE, 8'h11); send(16'hFFFF, 8'h22);
        ce_wr_dat = 1'b1; adr = 16'h0000; rx_dat = 8'h33; ok_rx_bl = 1'b1;
        tick();
        ce_wr_dat = 1'b0; ok_rx_bl = 1'b0;
        repeat (3) tick();
        chk("t5_blok", 32'(bl_ok), 1);
        chk("t5_len",  32'(bl_len), 3);
        chk("t5_nwr",  32'(wa_q.size()), 3);
        chk_wr("t5_w0", 0, 16'hFFFE, 8'h11);
        chk_wr("t5_w1", 1, 16'hFFFF, 8'h22);
        chk_wr("t5_w2", 2, 16'h0000, 8'h33);

        // Strobe and ok during COMMIT: one error, data unaffected
        clr_log();
        mem_gnt = 1'b0;
        send(16'h0500, 8'h71); send(16'h0501, 8'h72); send(16'h0502, 8'h73);
        ok_rx_bl = 1'b1; tick(); ok_rx_bl = 1'b0;
        chk("t6_err_pre", 32'(err_cnt), 2);
        send(16'h0503, 8'hEE);
        chk("t6_err_lost", 32'(err_cnt), 3);
        ok_rx_bl = 1'b1; tick(); ok_rx_bl = 1'b0;
        chk("t6_err_once", 32'(err_cnt), 3);
        mem_gnt = 1'b1;
        repeat (3) tick();
        chk("t6_blok", 32'(bl_ok), 1);
        chk("t6_len",  32'(bl_len), 3);
        chk("t6_nwr",  32'(wa_q.size()), 3);
        chk_wr("t6_w0", 0, 16'h0500, 8'h71);
        chk_wr("t6_w1", 1, 16'h0501, 8'h72);
        chk_wr("t6_w2", 2, 16'h0502, 8'h73);
        tick();

        // Empty block acknowledged from IDLE
        ok_rx_bl = 1'b1; tick(); ok_rx_bl = 1'b0;
        chk("t7_blok", 32'(bl_ok), 1);
        chk("t7_len",  32'(bl_len), 0);
        chk("t7_busy", 32'(busy), 0);
        tick();
        chk("t7_blok_pulse", 32'(bl_ok), 0);

        // Reset in the middle of a commit
        clr_log();
        send(16'h0600, 8'h61); send(16'h0601, 8'h62); send(16'h0602, 8'h63); send(16'h0603, 8'h64);
        ok_rx_bl = 1'b1; tick(); ok_rx_bl = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t8_req",  32'(mem_req), 0);
        chk("t8_we",   32'(mem_we), 0);
        chk("t8_err",  32'(err_cnt), 0);
        chk("t8_busy", 32'(busy), 0);
        repeat (4) tick();
        chk("t8_nwr",  32'(wa_q.size()), 2);
        chk_wr("t8_w0", 0, 16'h0600, 8'h61);
        chk_wr("t8_w1", 1, 16'h0601, 8'h62);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
